// File: rtl/sa_ram_pkg.sv
// sa_ram_pkg
//   Shared definitions for the sa_ram_rwsp_param RAM model:
//   - init_state_t : self-clear sequencer state encoding (INIT=0, READY=1)
//   - clog2        : address width helper, never returns less than 1
//   - seg_parity   : even-parity bit for one write segment. The argument is
//                    zero-extended to PAR_W_MAX, which leaves parity unchanged.
package sa_ram_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } init_state_t;

   localparam int PAR_W_MAX = 4096;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return (res < 1) ? 1 : res;
   endfunction

   function automatic logic seg_parity(input logic [PAR_W_MAX-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sa_ram_rwsp_param_if.sv
// sa_ram_rwsp_param_if
//   Read/write port bundle for sa_ram_rwsp_param.
//   ra/re    : read address, read enable (samples ra)
//   ore      : output register enable
//   dout     : registered read data; dout_vld marks data from a completed read
//   wa/we    : write address, write enable
//   wmask    : per-segment write enable; di : write data
//   master   : the RAM user; slave : the RAM model
interface sa_ram_rwsp_param_if
   import sa_ram_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WIDTH = 512,
   parameter int SEG_W = 64
);
   localparam int AW   = clog2(DEPTH);
   localparam int SEGS = WIDTH / SEG_W;

   logic [AW-1:0]    ra;
   logic             re;
   logic             ore;
   logic [WIDTH-1:0] dout;
   logic             dout_vld;
   logic [AW-1:0]    wa;
   logic             we;
   logic [SEGS-1:0]  wmask;
   logic [WIDTH-1:0] di;

   modport master (
      output ra, re, ore, wa, we, wmask, di,
      input  dout, dout_vld
   );

   modport slave (
      input  ra, re, ore, wa, we, wmask, di,
      output dout, dout_vld
   );

endinterface

// File: rtl/sa_ram_init_seq.sv
// sa_ram_init_seq
//   Post-reset self-clear sequencer. After rstn deasserts it stays in INIT for
//   exactly DEPTH cycles, issuing one zero-write per cycle to addresses
//   0..DEPTH-1, then moves to READY until the next reset.
//   Ports:
//     clk, rstn  : clock, asynchronous active-low reset
//     init_we    : clear-write strobe for the array
//     init_wa    : address being cleared
//     init_busy  : high while clearing (user accesses are dropped)
module sa_ram_init_seq
   import sa_ram_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW   = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rstn,
   output logic          init_we,
   output logic [AW-1:0] init_wa,
   output logic          init_busy
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   init_state_t   state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      init_we   = 1'b0;
      init_wa   = cnt;
      init_busy = 1'b0;
      case (state)
         ST_INIT: begin
            init_we   = 1'b1;
            init_busy = 1'b1;
            cnt_nxt   = cnt + AW'(1);
            if (cnt == LAST_ADDR) begin
               state_nxt = ST_READY;
               cnt_nxt   = '0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sa_ram_rwsp_param.sv
// sa_ram_rwsp_param
//   Parametrised 1R1W synchronous RAM model: registered read address,
//   output register with enable, per-segment write mask, optional
//   write-first bypass and a post-reset self-clear sequencer.
//   Optional feature macro: SA_RAM_PARITY_EN (per-segment even parity with a
//   sticky error flag); without it perr is tied low.
//   Ports:
//     clk, rstn      : clock, asynchronous active-low reset
//     bus (slave)    : ra/re/ore/dout/dout_vld/wa/we/wmask/di
//     init_busy      : self-clear in progress, re/we ignored
//     perr           : sticky parity error
//     pwrbus_ram_pd  : power-down bus, unused by the model
module sa_ram_rwsp_param
   import sa_ram_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int WIDTH  = 512,
   parameter int SEG_W  = 64,
   parameter int BYPASS = 1
) (
   input  logic                clk,
   input  logic                rstn,
   sa_ram_rwsp_param_if.slave  bus,
   output logic                init_busy,
   output logic                perr,
   input  logic [31:0]         pwrbus_ram_pd
);

   localparam int AW   = clog2(DEPTH);
   localparam int SEGS = WIDTH / SEG_W;
   // Extra bit so DEPTH itself is representable when DEPTH is a power of two.
   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             init_we;
   logic [AW-1:0]    init_wa;
   logic             ready;
   logic             wa_ok;
   logic             ra_ok;
   logic             usr_we;
   logic             usr_re;

   logic [AW-1:0]    ra_d;
   logic             rd_pend;
   logic [WIDTH-1:0] dout_q;
   logic             vld_q;

   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] cap_word;
   logic [SEGS-1:0]  fwd;

   logic             unused_pwrbus;
   assign unused_pwrbus = ^pwrbus_ram_pd;

   sa_ram_init_seq #(
      .DEPTH (DEPTH)
   ) u_init_seq (
      .clk       (clk),
      .rstn      (rstn),
      .init_we   (init_we),
      .init_wa   (init_wa),
      .init_busy (init_busy)
   );

   assign ready  = ~init_busy;
   assign wa_ok  = {1'b0, bus.wa} < DEPTH_V;
   assign ra_ok  = {1'b0, ra_d} < DEPTH_V;
   assign usr_we = ready & bus.we & wa_ok;
   assign usr_re = ready & bus.re;

   // Array write: self-clear has priority (user writes are dropped anyway while busy).
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_wa] <= '0;
      end else if (usr_we) begin
         for (int s = 0; s < SEGS; s++) begin
            if (bus.wmask[s]) begin
               mem[bus.wa][s*SEG_W +: SEG_W] <= bus.di[s*SEG_W +: SEG_W];
            end
         end
      end
   end

   // Capture data: array word at ra_d, with masked segments of a colliding
   // write forwarded when BYPASS is set. Out-of-range ra_d reads as zero.
   always_comb begin
      rd_word = '0;
      fwd     = '0;
      if (ra_ok) begin
         rd_word = mem[ra_d];
      end
      cap_word = rd_word;
      if (BYPASS != 0 && usr_we && bus.wa == ra_d) begin
         for (int s = 0; s < SEGS; s++) begin
            if (bus.wmask[s]) begin
               cap_word[s*SEG_W +: SEG_W] = bus.di[s*SEG_W +: SEG_W];
               fwd[s]                     = 1'b1;
            end
         end
      end
   end

   // Read address register and output register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ra_d    <= '0;
         rd_pend <= 1'b0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         if (usr_re) begin
            ra_d    <= bus.ra;
            rd_pend <= 1'b1;
         end else if (bus.ore) begin
            rd_pend <= 1'b0;
         end
         if (bus.ore) begin
            dout_q <= cap_word;
            vld_q  <= rd_pend;
         end
      end
   end

   assign bus.dout     = dout_q;
   assign bus.dout_vld = vld_q;

`ifdef SA_RAM_PARITY_EN
   logic [SEGS-1:0] par_mem [DEPTH];
   logic [SEGS-1:0] rd_par;
   logic [SEGS-1:0] mism;
   logic            perr_q;

   always_ff @(posedge clk) begin
      if (init_we) begin
         par_mem[init_wa] <= '0;
      end else if (usr_we) begin
         for (int s = 0; s < SEGS; s++) begin
            if (bus.wmask[s]) begin
               par_mem[bus.wa][s] <= seg_parity(PAR_W_MAX'(bus.di[s*SEG_W +: SEG_W]));
            end
         end
      end
   end

   // Forwarded segments bypass the stored parity, so they can never flag.
   always_comb begin
      rd_par = '0;
      mism   = '0;
      if (ra_ok) begin
         rd_par = par_mem[ra_d];
      end
      for (int s = 0; s < SEGS; s++) begin
         mism[s] = ~fwd[s] &
                   (rd_par[s] != seg_parity(PAR_W_MAX'(rd_word[s*SEG_W +: SEG_W])));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perr_q <= 1'b0;
      end else if (bus.ore && rd_pend && (|mism)) begin
         perr_q <= 1'b1;
      end
   end

   assign perr = perr_q;
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd;
   assign perr       = 1'b0;
`endif

endmodule
